// File: rtl/control_pkg.sv
// control_pkg -- shared definitions for the multicycle control unit.
//   estado_t      : FSM state encoding
//   LOAD/STORE/BEQ: opcode constants (instr[6:0]); F3_BEQ is the only
//                   accepted funct3 for branches
//   IMM_*         : imm_sel codes
//   ALU_*         : alu_op codes
//   imm_de_opcode : immediate format from instr[6:4]
package control_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_READ,
    WRITEBACK,
    MEM_WRITE,
    BRANCH,
    ILLEGAL
  } estado_t;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BEQ    = 7'b1100011;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_PC4 = 2'b10;

  // instr[6:4] alone distinguishes the three supported formats.
  function automatic logic [1:0] imm_de_opcode(input logic [2:0] op_hi);
    case (op_hi)
      3'b010:  return IMM_S;
      3'b110:  return IMM_B;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/decodificador_opcode.sv
// decodificador_opcode -- combinational opcode classifier.
//   instr    : instruction word (opcode [6:0], funct3 [14:12])
//   is_load  : opcode LOAD
//   is_store : opcode STORE
//   is_beq   : opcode BEQ with funct3 000
//   illegal  : none of the above
module decodificador_opcode
  import control_pkg::*;
#(
  parameter int Ancho = 32
) (
  input  logic [Ancho-1:0] instr,
  output logic             is_load,
  output logic             is_store,
  output logic             is_beq,
  output logic             illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_campos;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  assign is_load  = (opcode == LOAD);
  assign is_store = (opcode == STORE);
  assign is_beq   = (opcode == BEQ) && (funct3 == F3_BEQ);
  assign illegal  = !(is_load || is_store || is_beq);

  // Register fields and immediates are irrelevant to classification.
  assign unused_campos = ^{instr[Ancho-1:15], instr[11:7]};

endmodule

// File: rtl/unidad_control.sv
// unidad_control -- multicycle Moore control unit (load / store / beq).
//   clk, rst_n       : clock, asynchronous active-low reset
//   instr            : instruction word from the IR
//   mem_ack          : memory completion (only honoured while mem_req=1)
//   zero             : ALU zero flag (drives pc_write in BRANCH)
//   mem_req, mem_we, addr_sel          : memory interface controls
//   ir_write, pc_write, reg_write      : register write enables
//   pc_src, imm_sel, alu_src, alu_op   : datapath selects
//   instr_done       : one-cycle pulse when an instruction retires
//   trap             : illegal instruction seen; sticky until reset
//   retire_cnt       : retired-instruction counter, only when the
//                      RETIRE_CNT_EN macro is defined
module unidad_control
  import control_pkg::*;
#(
  parameter int Ancho = 32,
  parameter int Bits  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Ancho-1:0] instr,
  input  logic             mem_ack,
  input  logic             zero,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             pc_src,
  output logic [1:0]       imm_sel,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             instr_done,
  output logic             trap
`ifdef RETIRE_CNT_EN
  ,
  output logic [Bits-1:0]  retire_cnt
`endif
);

  estado_t estado, estado_sig;
  logic    armado;    // set by the first edge after reset release
  logic    es_store;  // load/store choice captured in DECODE
  logic    is_load, is_store, is_beq, illegal;

  decodificador_opcode #(.Ancho(Ancho)) u_decodificador (
    .instr    (instr),
    .is_load  (is_load),
    .is_store (is_store),
    .is_beq   (is_beq),
    .illegal  (illegal)
  );

  // IDLE waits for armado so that the first FETCH lands on the second
  // rising edge after rst_n is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= IDLE;
      armado   <= 1'b0;
      es_store <= 1'b0;
    end else begin
      estado <= estado_sig;
      armado <= 1'b1;
      if (estado == DECODE) es_store <= is_store;
    end
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:      if (armado) estado_sig = FETCH;
      FETCH:     if (mem_ack) estado_sig = DECODE;
      DECODE: begin
        if (illegal)     estado_sig = ILLEGAL;
        else if (is_beq) estado_sig = BRANCH;
        else             estado_sig = MEM_ADDR;
      end
      MEM_ADDR:  estado_sig = es_store ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (mem_ack) estado_sig = WRITEBACK;
      WRITEBACK: estado_sig = FETCH;
      MEM_WRITE: if (mem_ack) estado_sig = FETCH;
      BRANCH:    estado_sig = FETCH;
      ILLEGAL:   estado_sig = ILLEGAL;
      default:   estado_sig = IDLE;
    endcase
  end

  // Outputs come from the state; the few that fire on mem_ack or zero are
  // qualified by a state that already has mem_req high (or is BRANCH), so
  // a stray acknowledge in any other state has no effect.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    pc_src     = 1'b0;
    imm_sel    = IMM_I;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    trap       = 1'b0;
    case (estado)
      FETCH: begin
        mem_req  = 1'b1;
        alu_op   = ALU_PC4;
        ir_write = mem_ack;
        pc_write = mem_ack;
      end
      DECODE: imm_sel = imm_de_opcode(instr[6:4]);
      MEM_ADDR: begin
        imm_sel = imm_de_opcode(instr[6:4]);
        alu_src = 1'b1;
        alu_op  = ALU_ADD;
      end
      MEM_READ: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
      end
      WRITEBACK: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        addr_sel   = 1'b1;
        instr_done = mem_ack;
      end
      BRANCH: begin
        imm_sel    = imm_de_opcode(instr[6:4]);
        alu_op     = ALU_SUB;
        pc_src     = 1'b1;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      ILLEGAL: trap = 1'b1;
      default: ;
    endcase
  end

`ifdef RETIRE_CNT_EN
  // ILLEGAL never pulses instr_done, so the count holds there.
  logic [Bits-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt_q <= '0;
    else if (instr_done) cnt_q <= cnt_q + {{(Bits-1){1'b0}}, 1'b1};
  end

  assign retire_cnt = cnt_q;
`else
  localparam int unused_bits = Bits;
`endif

endmodule

// File: doc/unidad_control.md
UNIDAD_CONTROL -- requirements
Module: unidad_control

Interface
REQ-001 Parameter Ancho, default 32: instruction width in bits.
REQ-002 Parameter Bits, default 64: datapath and retire-counter width.
REQ-003 clk  input  1  single clock, all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 instr  input  Ancho  instruction word from the IR (opcode [6:0], funct3 [14:12]).
REQ-006 mem_ack  input  1  memory completion, sampled on the rising edge while mem_req=1.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_req  output  1  memory access request, held high until acknowledged.
REQ-009 mem_we  output  1  1=write, 0=read; valid while mem_req=1.
REQ-010 addr_sel  output  1  memory address source: 0=PC, 1=ALU result.
REQ-011 ir_write, pc_write, reg_write  output  1 each  register write enables.
REQ-012 pc_src  output  1  PC input: 0=PC+4, 1=branch target.
REQ-013 imm_sel  output  2  immediate format: 00=I (load), 01=S (store), 10=B (branch).
REQ-014 alu_src  output  1  ALU operand B: 0=rs2, 1=immediate.
REQ-015 alu_op  output  2  00=ADD, 01=SUB, 10=PC+4.
REQ-016 instr_done  output  1  one-cycle pulse on instruction retire.
REQ-017 trap  output  1  illegal instruction; sticky.

Function
REQ-018 The block SHALL be a Moore FSM with states IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, WRITEBACK, MEM_WRITE, BRANCH, ILLEGAL.
- Outputs are decoded from the state register only.
REQ-019 IDLE SHALL drive all outputs 0 and go to FETCH on the next edge.
REQ-020 FETCH SHALL assert mem_req=1, mem_we=0, addr_sel=0, alu_op=10.
- Stays in FETCH while mem_ack=0.
- On the edge with mem_ack=1: ir_write=1 and pc_write=1 are active in that cycle; next state is DECODE.
REQ-021 DECODE SHALL last one cycle and classify instr.
- Load: opcode 0000011 -> MEM_ADDR.
- Store: opcode 0100011 -> MEM_ADDR.
- Branch: opcode 1100011 with funct3=000 -> BRANCH.
- Anything else -> ILLEGAL.
REQ-022 imm_sel SHALL be driven from instr[6:4] in DECODE, MEM_ADDR and BRANCH: 000->00, 010->01, 110->10; it is 00 in all other states.
REQ-023 MEM_ADDR SHALL assert alu_src=1, alu_op=00 for one cycle, then go to MEM_READ (load) or MEM_WRITE (store).
REQ-024 MEM_READ SHALL assert mem_req=1, mem_we=0, addr_sel=1 until mem_ack, then go to WRITEBACK.
REQ-025 WRITEBACK SHALL assert reg_write=1 and instr_done=1 for one cycle, then go to FETCH.
REQ-026 MEM_WRITE SHALL assert mem_req=1, mem_we=1, addr_sel=1 until mem_ack.
- On ack: instr_done=1 is active in that cycle; next state is FETCH.
REQ-027 BRANCH SHALL assert alu_op=01, alu_src=0, pc_src=1, pc_write=zero and instr_done=1 for one cycle, then go to FETCH.
REQ-028 ILLEGAL SHALL hold trap=1 with all other outputs 0 until reset.
REQ-029 With zero-wait acknowledgement, latency SHALL be load 5, store 4, branch 3 cycles from FETCH entry back to FETCH entry.
REQ-030 mem_req SHALL never drop before mem_ack, and mem_we/addr_sel SHALL stay stable while mem_req=1.
REQ-031 A mem_ack received while mem_req=0 SHALL be ignored.

Reset
REQ-032 While rst_n=0, state SHALL be IDLE and every output (including trap) SHALL be 0, regardless of clk.
REQ-033 Reset asserted mid-access SHALL abort the access immediately (mem_req drops asynchronously); no write enable fires.
REQ-034 The first FETCH SHALL begin on the second rising edge after rst_n deasserts.

Configuration
REQ-035 Macro RETIRE_CNT_EN SHALL control an optional retire counter.
- Defined: adds output retire_cnt [Bits-1:0]. Reset value 0; increments on every instr_done; wraps from all-ones to 0; holds in ILLEGAL.
- Undefined: the port and the counter are absent.
- All other behaviour is identical with or without the macro.

Structure
REQ-036 Package control_pkg SHALL hold the state enum, the opcode constants (LOAD, STORE, BEQ), the imm_sel codes and the alu_op codes.
REQ-037 Opcode classification SHALL live in combinational sub-module decodificador_opcode (instr in, {is_load, is_store, is_beq, illegal} out).

Verification
REQ-038 Load 0x00A13083, mem_ack immediate -> FETCH/DECODE/MEM_ADDR/MEM_READ/WRITEBACK; imm_sel=00; reg_write for 1 cycle; instr_done after 5 cycles.
REQ-039 Store 0x00112423, mem_ack delayed 3 cycles -> mem_req=1 and mem_we=1 held stable for 4 cycles; imm_sel=01; no reg_write.
REQ-040 Beq 0x00208463 with zero=1 -> pc_write=1, pc_src=1 in BRANCH. With zero=0 -> pc_write=0. Both retire in 3 cycles.
REQ-041 Instruction 0x00000033 -> ILLEGAL, trap=1 sticky; mem_ack pulses produce no outputs; rst_n low clears trap.
REQ-042 rst_n pulsed low during MEM_WRITE wait -> mem_req=0 immediately, state IDLE, FETCH two edges after release.
REQ-043 With RETIRE_CNT_EN defined, run 3 loads and 2 branches -> retire_cnt=5. Preload near all-ones -> wraps to 0.
